neopixel_chase_driver: RTL and testbench
========================================

# neopixel_chase_driver

Parametrised WS2812 ("NeoPixel") strip driver with a built-in bit serializer and colour-pattern generator. It streams N_PIXELS 24-bit GRB words per frame, followed by a latch (reset) gap. It generalises the fixed 18-pixel rotating-colour demo to a configurable pixel count, configurable bit timing, four pattern modes and runtime brightness. It sits between the board top level and the strip data pin; its only output to the strip is `dout`.

## Interface
Parameters:
- N_PIXELS, 18, pixels per frame (≥1)
- T_BIT, 26, clock cycles per data bit (1.25 µs at 20.46 MHz)
- T0H, 8, high cycles for a '0' bit (0 < T0H < T1H)
- T1H, 16, high cycles for a '1' bit (T1H < T_BIT)
- T_RST, 1228, low cycles of the latch gap after each frame (≥60 µs)
- HOLD_FRAMES, 30, frames per pattern phase step (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run frames continuously while high
- mode  in  2  0 = CHASE, 1 = SOLID, 2 = WHITE, 3 = OFF
- brightness  in  8  channel intensity value
- dout  out  1  serial data to strip
- busy  out  1  high from frame start through end of latch gap
- frame_done  out  1  one-cycle pulse at end of each latch gap
- phase  out  2  current pattern phase, 0..2

## Operation
- Reset is synchronous and active-high. On reset all outputs are 0 (dout, busy, frame_done, phase), and the phase/frame counters, pixel index and bit counters are cleared. Reset takes priority over every other input.
- States: IDLE, SEND, LATCH.
- IDLE: dout = 0, busy = 0. If enable = 1, latch mode_q and bright_q, load the pixel-0 word, and go to SEND.
- SEND: serialise the word MSB first (G7 … G0, R7 … R0, B7 … B0). Each bit lasts exactly T_BIT cycles: dout = 1 for T0H cycles (bit 0) or T1H cycles (bit 1), then 0 for the rest. After bit 0 of pixel p:
  - if p < N_PIXELS−1, load word p+1 and continue with no gap, so bit periods are contiguous across pixel boundaries;
  - otherwise go to LATCH.
- LATCH: dout = 0 for T_RST cycles. In the final cycle, frame_done pulses and the frame counter increments. When the counter reaches HOLD_FRAMES it clears and phase advances (2 wraps to 0). Next state is SEND with a fresh frame (re-latching mode/brightness) if enable = 1, else IDLE.
- Word for pixel p, with B = bright_q and idx = (p + phase) mod 3 in CHASE or phase in SOLID:
  - CHASE / SOLID: idx 0 → {B, 0, 0}, idx 1 → {0, B, 0}, idx 2 → {0, 0, B} (GRB order).
  - WHITE: {B, B, B}.
  - OFF: 24'h000000. The frame is still transmitted in full.
- (p + phase) mod 3 is computed without a divider: keep a running mod-3 counter seeded with phase at frame start and stepped per pixel.
- mode and brightness changes mid-frame are ignored until the next frame start.
- enable falling mid-frame: the current frame, including its latch gap, completes; then the block goes to IDLE.
- Counter widths: pixel index $clog2(N_PIXELS) (min 1), bit-cycle counter $clog2(T_BIT), latch counter $clog2(T_RST), frame counter $clog2(HOLD_FRAMES+1).

## Timing
- All outputs are registered.
- If enable is sampled high in IDLE at edge e, busy and dout are both 1 in the cycle after e.
- Frame length: N_PIXELS·24·T_BIT cycles in SEND, plus T_RST cycles in LATCH.
- frame_done is high for exactly one cycle, coincident with the last LATCH cycle. busy is still 1 in that cycle.
- Back-to-back frames: the first high cycle of the next frame immediately follows the last LATCH cycle.
- phase updates in the cycle after the frame_done pulse that completes a hold period.
- Reset asserted mid-bit: dout is 0 in the cycle after the reset edge. Restart begins at pixel 0 with phase 0.

## Test plan
- N_PIXELS=3, brightness=0x30, mode=0, HOLD_FRAMES=30; reset then enable. Required: decoded words 0x300000, 0x003000, 0x000030; every high pulse is 8 or 16 cycles; every bit period is 26 cycles, including across pixel boundaries; 1228 low cycles; then frame_done is a single-cycle pulse.
- HOLD_FRAMES=2, mode=0. Required: frames 1–2 start with 0x300000; frame 3 starts with 0x003000 and phase=1; frame 7 returns to phase=0.
- mode=1, 2, 3 with brightness=0x30 and phase=0. Required: every pixel 0x300000 (SOLID), 0x303030 (WHITE), 0x000000 (OFF).
- Deassert enable during pixel 1 of 3. Required: pixels 1 and 2 and the full latch gap are sent, then busy=0 and dout=0, with no further high pulses.
- Change mode from 0 to 2 mid-frame. Required: the rest of the current frame keeps CHASE words; the next frame is all 0x303030.
- Assert rst for one cycle during a bit high time. Required: dout=0, busy=0, phase=0 the next cycle; with enable held, the next frame restarts cleanly at pixel 0.

Source files
------------

// File: rtl/neopixel_chase_driver.sv
// WS2812 strip driver: serialises N_PIXELS GRB words per frame, then holds a latch gap.
// Pattern words come from a chase/solid/white/off generator with runtime brightness.
module neopixel_chase_driver #(
  parameter int N_PIXELS    = 18,
  parameter int T_BIT       = 26,
  parameter int T0H         = 8,
  parameter int T1H         = 16,
  parameter int T_RST       = 1228,
  parameter int HOLD_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [7:0] brightness,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] phase
);

  localparam int PIX_W = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1;
  localparam int CYC_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int LAT_W = (T_RST > 1) ? $clog2(T_RST) : 1;
  localparam int FRM_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIXELS - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] HIGH0    = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] HIGH1    = CYC_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RST - 1);
  localparam logic [FRM_W-1:0] FRM_HOLD = FRM_W'(HOLD_FRAMES);
  localparam logic [4:0]       BIT_LAST = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [4:0]       bit_q, bit_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [FRM_W-1:0] frm_inc;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       mod3_q, mod3_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [23:0]      word_q, word_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       bright_q, bright_d;
  logic             start_frame;

  function automatic logic [1:0] mod3_step(input logic [1:0] v);
    mod3_step = (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // SOLID colours every pixel by phase; CHASE uses the per-pixel running index.
  function automatic logic [23:0] pixel_word(input logic [1:0] md, input logic [7:0] b,
                                             input logic [1:0] chase_idx, input logic [1:0] ph);
    logic [1:0]  idx;
    logic [23:0] w;
    idx = (md == 2'd1) ? ph : chase_idx;
    w   = 24'h000000;
    case (md)
      2'd0, 2'd1: begin
        case (idx)
          2'd0:    w = {b, 8'h00, 8'h00};
          2'd1:    w = {8'h00, b, 8'h00};
          default: w = {8'h00, 8'h00, b};
        endcase
      end
      2'd2:    w = {b, b, b};
      default: w = 24'h000000;
    endcase
    pixel_word = w;
  endfunction

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    lat_d       = lat_q;
    frm_d       = frm_q;
    phase_d     = phase_q;
    mod3_d      = mod3_q;
    word_d      = word_q;
    mode_d      = mode_q;
    bright_d    = bright_q;
    start_frame = 1'b0;
    frm_inc     = frm_q + 1'b1;

    case (state_q)
      ST_IDLE: start_frame = enable;
      ST_SEND: begin
        if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d = '0;
          if (bit_q != BIT_LAST) begin
            bit_d  = bit_q + 5'd1;
            word_d = {word_q[22:0], 1'b0};
          end else if (pix_q != PIX_LAST) begin
            bit_d  = 5'd0;
            pix_d  = pix_q + 1'b1;
            mod3_d = mod3_step(mod3_q);
            word_d = pixel_word(mode_q, bright_q, mod3_step(mod3_q), phase_q);
          end else begin
            state_d = ST_LATCH;
            lat_d   = '0;
          end
        end
      end
      ST_LATCH: begin
        if (lat_q != LAT_LAST) begin
          lat_d = lat_q + 1'b1;
        end else begin
          if (frm_inc == FRM_HOLD) begin
            frm_d   = '0;
            phase_d = mod3_step(phase_q);
          end else begin
            frm_d = frm_inc;
          end
          start_frame = enable;
          if (!enable) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame sees the phase that takes effect at this same edge.
    if (start_frame) begin
      state_d  = ST_SEND;
      pix_d    = '0;
      cyc_d    = '0;
      bit_d    = 5'd0;
      mod3_d   = phase_d;
      mode_d   = mode;
      bright_d = brightness;
      word_d   = pixel_word(mode, brightness, phase_d, phase_d);
    end

    busy_d       = (state_d != ST_IDLE);
    dout_d       = (state_d == ST_SEND) && (cyc_d < (word_d[23] ? HIGH1 : HIGH0));
    frame_done_d = (state_d == ST_LATCH) && (lat_d == LAT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pix_q        <= '0;
      cyc_q        <= '0;
      bit_q        <= 5'd0;
      lat_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 2'd0;
      mod3_q       <= 2'd0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      lat_q        <= lat_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      mod3_q       <= mod3_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Word and latched frame settings are only consumed while SEND is active.
  always_ff @(posedge clk) begin
    word_q   <= word_d;
    mode_q   <= mode_d;
    bright_q <= bright_d;
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_neopixel_chase_driver.sv
// Bench for neopixel_chase_driver: decodes the dout waveform into bits and words and
// compares against a frame-level model of the pattern generator.
module tb_neopixel_chase_driver;

  localparam int NP   = 3;
  localparam int TB   = 26;
  localparam int T0   = 8;
  localparam int T1   = 16;
  localparam int TR   = 1228;
  localparam int HOLD = 2;
  localparam int NBITS = 24 * NP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] brightness = 8'h30;
  logic       dout;
  logic       busy;
  logic       frame_done;
  logic [1:0] phase;

  neopixel_chase_driver #(
    .N_PIXELS(NP), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RST(TR), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .brightness(brightness),
    .dout(dout), .busy(busy), .frame_done(frame_done), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pattern rule: CHASE index (p+phase) mod 3, SOLID index phase; index selects G, R or B.
  function automatic logic [23:0] ref_word(input int md, input int b, input int ph, input int p);
    int idx;
    logic [7:0] bb;
    bb = 8'(b);
    case (md)
      0: idx = (p + ph) % 3;
      1: idx = ph;
      2: return {bb, bb, bb};
      default: return 24'h000000;
    endcase
    return 24'(bb) << (8 * (2 - idx));
  endfunction

  // Monitor / reference model state
  int          cyc = 0;
  int          nbits = 0;
  int          last_rise = 0;
  int          rise_cyc = 0;
  int          frames_m = 0;
  int          prev_mode = 0;
  int          prev_b = 0;
  int          pi, bi, width;
  bit          in_frame = 1'b0;
  bit          fd_prev = 1'b0;
  bit          fd_exp;
  logic        dout_prev = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_en = 1'b0;
  logic [23:0] exp_w [NP];
  logic [23:0] obs_w [NP];

  function automatic int phase_m();
    return (frames_m / HOLD) % 3;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk("rst_dout", int'(dout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_phase", int'(phase), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      in_frame = 1'b0;
      fd_prev  = 1'b0;
      frames_m = 0;
    end else if (!in_frame || fd_prev) begin
      chk("start_dout", int'(dout), int'(prev_en));
      chk("start_busy", int'(busy), int'(prev_en));
      fd_prev  = 1'b0;
      in_frame = 1'b0;
      if (prev_en) begin
        in_frame  = 1'b1;
        nbits     = 0;
        last_rise = cyc;
        rise_cyc  = cyc;
        chk("start_phase", int'(phase), phase_m());
        for (int p = 0; p < NP; p++) begin
          exp_w[p] = ref_word(prev_mode, prev_b, phase_m(), p);
          obs_w[p] = 24'h0;
        end
      end
    end else begin
      chk("busy_in_frame", int'(busy), 1);
      if (dout && !dout_prev) begin
        chk("pulse_before_latch", int'(nbits < NBITS), 1);
        if (nbits < NBITS) chk("bit_period", cyc - last_rise, TB);
        last_rise = cyc;
        rise_cyc  = cyc;
      end
      if (!dout && dout_prev && nbits < NBITS) begin
        pi    = nbits / 24;
        bi    = 23 - (nbits % 24);
        width = cyc - rise_cyc;
        chk("high_width", width, exp_w[pi][bi] ? T1 : T0);
        obs_w[pi][bi] = (width > (T0 + T1) / 2);
        nbits++;
      end
      fd_exp = (cyc - last_rise == TB + TR - 1);
      if (frame_done || fd_exp) chk("frame_done", int'(frame_done), int'(fd_exp));
      if (fd_exp) begin
        chk("latch_dout", int'(dout), 0);
        chk("latch_phase", int'(phase), phase_m());
        chk("bit_count", nbits, NBITS);
        for (int p = 0; p < NP; p++) chk("pixel_word", int'(obs_w[p]), int'(exp_w[p]));
        frames_m++;
        fd_prev = 1'b1;
      end
    end
    dout_prev = dout;
    prev_rst  = rst;
    prev_en   = enable;
    prev_mode = int'(mode);
    prev_b    = int'(brightness);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    chk("wait_frame_done", int'(seen), 1);
  endtask

  task automatic wait_rise(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      tick();
      if (dout) seen = 1'b1;
    end
    chk("wait_dout_rise", int'(seen), 1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // CHASE frames across three hold periods, phase wraps back to 0 at frame 7
    enable = 1'b1;
    repeat (6) wait_done(4000);
    repeat (900) tick();
    mode = 2'd2;
    wait_done(4000);
    wait_done(4000);

    // Random mode/brightness changes mid-frame, taking effect on the next frame
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(10, 1800)) tick();
      mode       = 2'($urandom_range(0, 3));
      brightness = 8'($urandom);
      wait_done(4000);
    end

    // Drop enable during pixel 1: frame and latch gap finish, then stay idle
    wait_rise(100);
    repeat (24 * TB + $urandom_range(0, 24 * TB - 1)) tick();
    enable = 1'b0;
    wait_done(4000);
    repeat (300) tick();

    // Reset inside a high pulse, then SOLID and OFF frames at phase 0
    mode       = 2'd1;
    brightness = 8'h30;
    enable     = 1'b1;
    wait_rise(100);
    repeat ($urandom_range(1, 6)) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (500) tick();
    mode = 2'd3;
    wait_done(4000);
    repeat (500) tick();
    enable = 1'b0;
    wait_done(4000);
    repeat (50) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
